ahb_master_arbiter: RTL and testbench

Two-master AHB-Lite arbiter that shares the single RAM/ROM slave port between the instruction-fetch master (I) and the load/store master (D). It accepts each master's address phase, buffers the losing one in a one-deep hold register, issues transfers to the slave port one at a time, and routes the data-phase response back to the owning master. It sits between the core's two bus interfaces and the slave address decoder.

---
 rtl/ahb_master_arbiter_if.sv | 56 +++++
 rtl/ahb_master_arbiter.sv | 217 +++++++++++++++++++++
 tb/tb_ahb_master_arbiter.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/ahb_master_arbiter_if.sv
// Bus bundle for the two-master AHB-Lite arbiter: the instruction-fetch
// master (i_*), the load/store master (d_*) and the shared slave port (s_*).
interface ahb_master_arbiter_if;

  // Instruction-fetch master address phase and response
  logic [1:0]  i_htrans;
  logic [31:0] i_haddr;
  logic [3:0]  i_hprot;
  logic [2:0]  i_hsize;
  logic        i_hready;
  logic        i_hresp;
  logic [31:0] i_hrdata;

  // Load/store master address phase, write data and response
  logic [1:0]  d_htrans;
  logic [31:0] d_haddr;
  logic [3:0]  d_hprot;
  logic [2:0]  d_hsize;
  logic        d_hwrite;
  logic [31:0] d_hwdata;
  logic        d_hready;
  logic        d_hresp;
  logic [31:0] d_hrdata;

  // Shared slave port
  logic [1:0]  s_htrans;
  logic [31:0] s_haddr;
  logic [3:0]  s_hprot;
  logic [2:0]  s_hsize;
  logic        s_hwrite;
  logic [31:0] s_hwdata;
  logic        s_hready;
  logic        s_hresp;
  logic [31:0] s_hrdata;

  // Environment view: the two cores drive requests, the slave drives responses
  modport master (
    output i_htrans, i_haddr, i_hprot, i_hsize,
    input  i_hready, i_hresp, i_hrdata,
    output d_htrans, d_haddr, d_hprot, d_hsize, d_hwrite, d_hwdata,
    input  d_hready, d_hresp, d_hrdata,
    input  s_htrans, s_haddr, s_hprot, s_hsize, s_hwrite, s_hwdata,
    output s_hready, s_hresp, s_hrdata
  );

  // Arbiter view: a slave to both cores, a master towards the slave port
  modport slave (
    input  i_htrans, i_haddr, i_hprot, i_hsize,
    output i_hready, i_hresp, i_hrdata,
    input  d_htrans, d_haddr, d_hprot, d_hsize, d_hwrite, d_hwdata,
    output d_hready, d_hresp, d_hrdata,
    output s_htrans, s_haddr, s_hprot, s_hsize, s_hwrite, s_hwdata,
    input  s_hready, s_hresp, s_hrdata
  );

endinterface

// File: rtl/ahb_master_arbiter.sv
// Two-master AHB-Lite arbiter. The instruction-fetch master (I, index 0) and
// the load/store master (D, index 1) share one slave port. Each master has at
// most one transfer outstanding; an accepted address phase that cannot be
// issued straight away is parked in that master's one-deep hold register and
// issued later as a NONSEQ. D normally wins; I wins once it has lost
// STARVE_LIMIT consecutive arbitrations.
module ahb_master_arbiter #(
  parameter int unsigned STARVE_LIMIT = 3
) (
  input logic hclk,
  input logic hresetn,
  ahb_master_arbiter_if.slave bus
);

  localparam int unsigned WAIT_W = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(STARVE_LIMIT);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  // Master indices double as the data-phase owner encoding
  localparam int unsigned MI = 0;
  localparam int unsigned MD = 1;
  localparam logic OWNER_I = 1'b0;
  localparam logic OWNER_D = 1'b1;

  // Everything the slave needs to see in an address phase
  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  prot;
    logic [2:0]  size;
    logic        write;
  } addr_phase_t;

  // Per-master view: nothing pending, parked in hold, or in slave data phase
  typedef enum logic [1:0] {
    MS_IDLE = 2'd0,
    MS_HELD = 2'd1,
    MS_DATA = 2'd2
  } mstate_e;

  logic [1:0]        req;
  logic [1:0]        accept;
  logic [1:0]        cand;
  logic [1:0]        hready;
  logic [1:0]        hresp;
  addr_phase_t [1:0] live;
  addr_phase_t [1:0] sel;

  logic              winner;
  logic              starved;
  logic              any_cand;
  logic              issue;
  addr_phase_t       win_ap;

  logic              dp_valid_q;
  logic              dp_valid_d;
  logic              dp_owner_q;
  logic              dp_owner_d;
  logic              lock_q;
  logic              lock_d;
  logic              lock_owner_q;
  logic              lock_owner_d;
  logic [WAIT_W-1:0] wait_cnt_q;
  logic [WAIT_W-1:0] wait_cnt_d;

  logic              unused_htrans_lsb;

  // Only NONSEQ/SEQ (htrans[1]) count as requests; bursts are flattened
  assign req = {bus.d_htrans[1], bus.i_htrans[1]};
  assign unused_htrans_lsb = bus.i_htrans[0] ^ bus.d_htrans[0];

  // Live address phases; I is a fetch port and never writes
  assign live[MI] = '{addr: bus.i_haddr, prot: bus.i_hprot, size: bus.i_hsize, write: 1'b0};
  assign live[MD] = '{addr: bus.d_haddr, prot: bus.d_hprot, size: bus.d_hsize, write: bus.d_hwrite};

  for (genvar gi = 0; gi < 2; gi++) begin : g_master
    localparam logic OWN = (gi == 0) ? OWNER_I : OWNER_D;

    mstate_e     state;
    logic        hready_m;
    logic        issued_now;
    logic        hold_valid_q;
    logic        hold_valid_d;
    addr_phase_t hold_q;
    addr_phase_t hold_d;

    // Classify this master from the hold register and data-phase ownership
    always_comb begin
      state = MS_IDLE;
      if (hold_valid_q) begin
        state = MS_HELD;
      end else if (dp_valid_q && (dp_owner_q == OWN)) begin
        state = MS_DATA;
      end
    end

    // Master-side hready: free when idle, slave-paced in data phase, stalled when held
    always_comb begin
      hready_m = 1'b1;
      case (state)
        MS_HELD: hready_m = 1'b0;
        MS_DATA: hready_m = bus.s_hready;
        default: hready_m = 1'b1;
      endcase
    end

    // Requests seen during reset must not reach the slave port
    assign accept[gi]  = hresetn & hready_m & req[gi];
    assign cand[gi]    = hold_valid_q | accept[gi];
    assign sel[gi]     = hold_valid_q ? hold_q : live[gi];
    assign hready[gi]  = hready_m;
    assign hresp[gi]   = dp_valid_q & (dp_owner_q == OWN) & bus.s_hresp;
    assign issued_now  = issue & (winner == OWN);

    // Hold register: drain on issue, park any accepted request that did not issue
    always_comb begin
      hold_valid_d = hold_valid_q;
      hold_d       = hold_q;
      if (issued_now) begin
        hold_valid_d = 1'b0;
      end
      if (accept[gi] && !issued_now) begin
        hold_valid_d = 1'b1;
        hold_d       = live[gi];
      end
    end

    // Hold register state
    always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
        hold_valid_q <= 1'b0;
        hold_q       <= '0;
      end else begin
        hold_valid_q <= hold_valid_d;
        hold_q       <= hold_d;
      end
    end
  end

  // Pick the address-phase owner; a stalled address phase keeps its owner
  always_comb begin
    starved = cand[MI] && (wait_cnt_q == WAIT_MAX);
    winner  = OWNER_I;
    if (lock_q) begin
      winner = lock_owner_q;
    end else if (cand[MD] && !starved) begin
      winner = OWNER_D;
    end
  end

  assign any_cand = |cand;
  assign issue    = any_cand & bus.s_hready;
  assign win_ap   = sel[winner];

  // Data-phase tracking, address-phase lock and I starvation counter
  always_comb begin
    dp_valid_d   = dp_valid_q;
    dp_owner_d   = dp_owner_q;
    lock_d       = lock_q;
    lock_owner_d = lock_owner_q;
    wait_cnt_d   = wait_cnt_q;
    if (bus.s_hready) begin
      lock_d = 1'b0;
      if (any_cand) begin
        dp_valid_d = 1'b1;
        dp_owner_d = winner;
        if (winner == OWNER_I || !cand[MI]) begin
          wait_cnt_d = '0;
        end else if (wait_cnt_q != WAIT_MAX) begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end else begin
        dp_valid_d = 1'b0;
        wait_cnt_d = '0;
      end
    end else if (any_cand) begin
      // Slave is stalling: whoever is on s_* now must stay there
      lock_d       = 1'b1;
      lock_owner_d = winner;
    end
  end

  // Shared control state
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      dp_valid_q   <= 1'b0;
      dp_owner_q   <= OWNER_I;
      lock_q       <= 1'b0;
      lock_owner_q <= OWNER_I;
      wait_cnt_q   <= '0;
    end else begin
      dp_valid_q   <= dp_valid_d;
      dp_owner_q   <= dp_owner_d;
      lock_q       <= lock_d;
      lock_owner_q <= lock_owner_d;
      wait_cnt_q   <= wait_cnt_d;
    end
  end

  // Slave port: combinational from the winning source so a direct issue adds no latency
  assign bus.s_htrans = any_cand ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign bus.s_haddr  = win_ap.addr;
  assign bus.s_hprot  = win_ap.prot;
  assign bus.s_hsize  = win_ap.size;
  assign bus.s_hwrite = (winner == OWNER_D) & win_ap.write;
  assign bus.s_hwdata = bus.d_hwdata;

  // Master responses; read data is broadcast, hready/hresp are steered
  assign bus.i_hready = hready[MI];
  assign bus.d_hready = hready[MD];
  assign bus.i_hresp  = hresp[MI];
  assign bus.d_hresp  = hresp[MD];
  assign bus.i_hrdata = bus.s_hrdata;
  assign bus.d_hrdata = bus.s_hrdata;

endmodule

// File: tb/tb_ahb_master_arbiter.sv
// Directed bench for ahb_master_arbiter: reset, contention, starvation,
// slave wait states, error response, reset mid-transfer and idle bus.
module tb_ahb_master_arbiter;

  localparam logic [1:0] NONSEQ = 2'b10;
  localparam logic [1:0] IDLE   = 2'b00;

  logic hclk = 1'b0;
  logic hresetn;
  int   checks   = 0;
  int   failures = 0;

  ahb_master_arbiter_if bus ();

  ahb_master_arbiter #(.STARVE_LIMIT(3)) dut (
    .hclk    (hclk),
    .hresetn (hresetn),
    .bus     (bus)
  );

  always #5 hclk = ~hclk;

  // Step to just after the next rising edge
  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset with an I request already present: must not reach the slave
    hresetn      = 1'b0;
    bus.i_htrans = NONSEQ; bus.i_haddr = 32'hA000_0F00; bus.i_hprot = 4'h0; bus.i_hsize = 3'd0;
    bus.d_htrans = IDLE;   bus.d_haddr = 32'h0; bus.d_hprot = 4'h0; bus.d_hsize = 3'd0;
    bus.d_hwrite = 1'b0;   bus.d_hwdata = 32'h0;
    bus.s_hready = 1'b1;   bus.s_hresp = 1'b0; bus.s_hrdata = 32'h0;
    #2;
    check("rst s_htrans", 32'(bus.s_htrans), 32'(IDLE));
    check("rst i_hready", 32'(bus.i_hready), 32'd1);
    check("rst d_hready", 32'(bus.d_hready), 32'd1);
    check("rst i_hresp",  32'(bus.i_hresp),  32'd0);
    check("rst d_hresp",  32'(bus.d_hresp),  32'd0);
    tick();
    bus.i_htrans = IDLE;
    hresetn = 1'b1;
    tick();

    // Contention: D wins first, I parks and issues next cycle
    bus.i_htrans = NONSEQ; bus.i_haddr = 32'hA000_0010; bus.i_hprot = 4'h3; bus.i_hsize = 3'd2;
    bus.d_htrans = NONSEQ; bus.d_haddr = 32'hB000_0020; bus.d_hprot = 4'h1; bus.d_hsize = 3'd0;
    bus.d_hwrite = 1'b0;
    #2;
    check("con0 s_haddr",  bus.s_haddr, 32'hB000_0020);
    check("con0 s_htrans", 32'(bus.s_htrans), 32'(NONSEQ));
    check("con0 s_hprot",  32'(bus.s_hprot), 32'h1);
    check("con0 i_hready", 32'(bus.i_hready), 32'd1);
    check("con0 s_hwrite", 32'(bus.s_hwrite), 32'd0);
    tick();
    bus.d_htrans = IDLE;
    #2;
    check("con1 s_haddr",  bus.s_haddr, 32'hA000_0010);
    check("con1 s_htrans", 32'(bus.s_htrans), 32'(NONSEQ));
    check("con1 s_hprot",  32'(bus.s_hprot), 32'h3);
    check("con1 s_hsize",  32'(bus.s_hsize), 32'd2);
    check("con1 d_hready", 32'(bus.d_hready), 32'd1);
    check("con1 i_hready", 32'(bus.i_hready), 32'd0);
    tick();
    bus.i_htrans = IDLE;
    bus.s_hrdata = 32'h1234_5678;
    #2;
    check("con2 i_hready", 32'(bus.i_hready), 32'd1);
    check("con2 i_hrdata", bus.i_hrdata, 32'h1234_5678);
    check("con2 d_hrdata", bus.d_hrdata, 32'h1234_5678);
    check("con2 s_htrans", 32'(bus.s_htrans), 32'(IDLE));

    // Starvation: both request continuously, grants go D,D,D,I repeating
    tick();
    bus.i_htrans = NONSEQ; bus.i_haddr = 32'hA000_0100;
    bus.d_htrans = NONSEQ; bus.d_haddr = 32'hB000_0200;
    for (int k = 0; k < 8; k++) begin
      #2;
      check($sformatf("stv%0d s_haddr", k), bus.s_haddr,
            ((k % 4) == 3) ? 32'hA000_0100 : 32'hB000_0200);
      tick();
    end
    // D's last request was parked when I won; it drains from hold
    bus.i_htrans = IDLE;
    bus.d_htrans = IDLE;
    #2;
    check("stv drain s_haddr",  bus.s_haddr, 32'hB000_0200);
    check("stv drain s_htrans", 32'(bus.s_htrans), 32'(NONSEQ));

    // Idle bus for four cycles
    for (int k = 0; k < 4; k++) begin
      tick();
      #2;
      check($sformatf("idle%0d s_htrans", k), 32'(bus.s_htrans), 32'(IDLE));
      check($sformatf("idle%0d i_hready", k), 32'(bus.i_hready), 32'd1);
      check($sformatf("idle%0d d_hready", k), 32'(bus.d_hready), 32'd1);
    end

    // Slave wait: D write data phase stalls two cycles, I request is parked
    tick();
    bus.d_htrans = NONSEQ; bus.d_haddr = 32'hB000_0004; bus.d_hwrite = 1'b1;
    #2;
    check("sw0 s_haddr",  bus.s_haddr, 32'hB000_0004);
    check("sw0 s_hwrite", 32'(bus.s_hwrite), 32'd1);
    tick();
    bus.d_htrans = IDLE; bus.d_hwrite = 1'b0; bus.d_hwdata = 32'hDEAD_BEEF;
    bus.s_hready = 1'b0;
    bus.i_htrans = NONSEQ; bus.i_haddr = 32'hA000_0040;
    #2;
    check("sw1 s_haddr",  bus.s_haddr, 32'hA000_0040);
    check("sw1 s_htrans", 32'(bus.s_htrans), 32'(NONSEQ));
    check("sw1 s_hwrite", 32'(bus.s_hwrite), 32'd0);
    check("sw1 s_hwdata", bus.s_hwdata, 32'hDEAD_BEEF);
    check("sw1 d_hready", 32'(bus.d_hready), 32'd0);
    check("sw1 i_hready", 32'(bus.i_hready), 32'd1);
    tick();
    bus.i_htrans = IDLE;
    #2;
    check("sw2 s_haddr",  bus.s_haddr, 32'hA000_0040);
    check("sw2 s_htrans", 32'(bus.s_htrans), 32'(NONSEQ));
    check("sw2 s_hwdata", bus.s_hwdata, 32'hDEAD_BEEF);
    check("sw2 d_hready", 32'(bus.d_hready), 32'd0);
    check("sw2 i_hready", 32'(bus.i_hready), 32'd0);
    tick();
    bus.s_hready = 1'b1;
    #2;
    check("sw3 d_hready", 32'(bus.d_hready), 32'd1);
    check("sw3 s_haddr",  bus.s_haddr, 32'hA000_0040);
    check("sw3 s_htrans", 32'(bus.s_htrans), 32'(NONSEQ));
    check("sw3 s_hwdata", bus.s_hwdata, 32'hDEAD_BEEF);
    check("sw3 i_hready", 32'(bus.i_hready), 32'd0);
    tick();
    bus.d_hwdata = 32'h0;
    #2;
    check("sw4 i_hready", 32'(bus.i_hready), 32'd1);
    check("sw4 s_htrans", 32'(bus.s_htrans), 32'(IDLE));

    // Error response on a D read: two-cycle ERROR seen only by D
    tick();
    bus.d_htrans = NONSEQ; bus.d_haddr = 32'hB000_0100; bus.d_hwrite = 1'b0;
    #2;
    check("err0 s_haddr", bus.s_haddr, 32'hB000_0100);
    tick();
    bus.d_htrans = IDLE;
    bus.s_hready = 1'b0; bus.s_hresp = 1'b1;
    #2;
    check("err1 d_hresp",  32'(bus.d_hresp),  32'd1);
    check("err1 d_hready", 32'(bus.d_hready), 32'd0);
    check("err1 i_hresp",  32'(bus.i_hresp),  32'd0);
    tick();
    bus.s_hready = 1'b1;
    #2;
    check("err2 d_hresp",  32'(bus.d_hresp),  32'd1);
    check("err2 d_hready", 32'(bus.d_hready), 32'd1);
    check("err2 i_hresp",  32'(bus.i_hresp),  32'd0);
    tick();
    bus.s_hresp = 1'b0;
    #2;
    check("err3 d_hresp", 32'(bus.d_hresp), 32'd0);
    check("err3 i_hresp", 32'(bus.i_hresp), 32'd0);

    // Reset while I is held: parked transfer must never reach the slave
    tick();
    bus.i_htrans = NONSEQ; bus.i_haddr = 32'hA000_0080;
    bus.d_htrans = NONSEQ; bus.d_haddr = 32'hB000_0080;
    #2;
    check("rm0 s_haddr", bus.s_haddr, 32'hB000_0080);
    tick();
    bus.d_htrans = IDLE;
    #2;
    check("rm1 i_hready", 32'(bus.i_hready), 32'd0);
    #1;
    hresetn = 1'b0;
    #1;
    check("rm2 s_htrans", 32'(bus.s_htrans), 32'(IDLE));
    check("rm2 i_hready", 32'(bus.i_hready), 32'd1);
    check("rm2 d_hready", 32'(bus.d_hready), 32'd1);
    tick();
    bus.i_htrans = IDLE;
    #2;
    check("rm3 s_htrans", 32'(bus.s_htrans), 32'(IDLE));
    tick();
    hresetn = 1'b1;
    #2;
    check("rm4 s_htrans", 32'(bus.s_htrans), 32'(IDLE));
    check("rm4 i_hready", 32'(bus.i_hready), 32'd1);
    tick();
    #2;
    check("rm5 s_htrans", 32'(bus.s_htrans), 32'(IDLE));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
